// File: rtl/reorder_buffer_pkg.sv
// Shared widths, entry encodings and the per-entry payload record for the reorder buffer.
package reorder_buffer_pkg;

  localparam int REG_POS_W = 5;
  localparam int DATA_W    = 32;

  typedef enum logic [1:0] {
    TYPE_REG    = 2'd0,
    TYPE_STORE  = 2'd1,
    TYPE_BRANCH = 2'd2
  } rob_type_e;

  typedef struct packed {
    rob_type_e             kind;
    logic [REG_POS_W-1:0]  rd;
    logic                  pred_jump;
    logic                  jump;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val;
    logic [DATA_W-1:0]     target;
  } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: allocate at tail, capture ALU/LSB writebacks, retire at head.
// Defining ROB_PERF_CNT_EN adds retirement and flush counters (perf_retired, perf_flush).
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_SIZE  = 16,
  parameter int ROB_POS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  output logic                  rob_full,
  output logic [ROB_POS_W-1:0]  rob_next_pos,
  input  logic                  issue,
  input  logic [REG_POS_W-1:0]  issue_rd,
  input  logic [1:0]            issue_type,
  input  logic                  issue_pred_jump,
  input  logic [DATA_W-1:0]     issue_pc,
  input  logic                  issue_ready,
  input  logic [DATA_W-1:0]     issue_val,
  input  logic                  alu_valid,
  input  logic [ROB_POS_W-1:0]  alu_pos,
  input  logic [DATA_W-1:0]     alu_val,
  input  logic                  alu_jump,
  input  logic [DATA_W-1:0]     alu_target,
  input  logic                  lsb_valid,
  input  logic [ROB_POS_W-1:0]  lsb_pos,
  input  logic [DATA_W-1:0]     lsb_val,
  input  logic [ROB_POS_W-1:0]  q1_pos,
  input  logic [ROB_POS_W-1:0]  q2_pos,
  output logic                  q1_ready,
  output logic [DATA_W-1:0]     q1_val,
  output logic                  q2_ready,
  output logic [DATA_W-1:0]     q2_val,
  output logic                  commit,
  output logic [REG_POS_W-1:0]  commit_rd,
  output logic [DATA_W-1:0]     commit_val,
  output logic [ROB_POS_W-1:0]  commit_pos,
  output logic                  store_commit,
  output logic                  rollback,
  output logic [DATA_W-1:0]     rollback_pc
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0]           perf_retired,
  output logic [31:0]           perf_flush
`endif
);

  localparam int CNT_W = ROB_POS_W + 1;

  logic [ROB_POS_W-1:0] head, tail;
  logic [CNT_W-1:0]     count;
  logic [ROB_SIZE-1:0]  busy, ready;
  rob_entry_t           ent [ROB_SIZE];
  rob_entry_t           hd;
  logic                 do_issue, do_retire;

  assign rob_full     = (count == CNT_W'(ROB_SIZE));
  assign rob_next_pos = tail;
  assign hd           = ent[head];
  assign do_issue     = issue && !rob_full && !rollback;
  assign do_retire    = !rollback && busy[head] && ready[head];

  // Same-cycle bus hits are forwarded so the decoder never waits a cycle for a fresh result.
  assign q1_ready = busy[q1_pos] && (ready[q1_pos] || (alu_valid && alu_pos == q1_pos)
                                    || (lsb_valid && lsb_pos == q1_pos));
  assign q1_val   = (alu_valid && alu_pos == q1_pos) ? alu_val :
                    (lsb_valid && lsb_pos == q1_pos) ? lsb_val : ent[q1_pos].val;
  assign q2_ready = busy[q2_pos] && (ready[q2_pos] || (alu_valid && alu_pos == q2_pos)
                                    || (lsb_valid && lsb_pos == q2_pos));
  assign q2_val   = (alu_valid && alu_pos == q2_pos) ? alu_val :
                    (lsb_valid && lsb_pos == q2_pos) ? lsb_val : ent[q2_pos].val;

  // NOTE: payload storage has no reset; busy/ready bits alone decide whether an entry means anything.
  always_ff @(posedge clk) begin
    if (rdy && !rollback) begin
      if (do_issue) begin
        ent[tail] <= '{kind: rob_type_e'(issue_type), rd: issue_rd, pred_jump: issue_pred_jump,
                       jump: 1'b0, pc: issue_pc, val: issue_val, target: '0};
      end
      if (alu_valid) begin
        ent[alu_pos].val    <= alu_val;
        ent[alu_pos].jump   <= alu_jump;
        ent[alu_pos].target <= alu_target;
      end
      if (lsb_valid) ent[lsb_pos].val <= lsb_val;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      busy         <= '0;
      ready        <= '0;
      commit       <= 1'b0;
      commit_rd    <= '0;
      commit_val   <= '0;
      commit_pos   <= '0;
      store_commit <= 1'b0;
      rollback     <= 1'b0;
      rollback_pc  <= '0;
    end else if (rdy) begin
      commit       <= 1'b0;
      store_commit <= 1'b0;
      rollback     <= 1'b0;
      if (rollback) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        busy  <= '0;
        ready <= '0;
      end else begin
        if (alu_valid) ready[alu_pos] <= 1'b1;
        if (lsb_valid) ready[lsb_pos] <= 1'b1;
        if (do_issue) begin
          busy[tail]  <= 1'b1;
          ready[tail] <= issue_ready;
          tail        <= tail + 1'b1;
        end
        if (do_retire) begin
          busy[head] <= 1'b0;
          head       <= head + 1'b1;
          commit_pos <= head;
          case (hd.kind)
            TYPE_REG: begin
              if (hd.rd != '0) begin
                commit     <= 1'b1;
                commit_rd  <= hd.rd;
                commit_val <= hd.val;
              end
            end
            TYPE_STORE: store_commit <= 1'b1;
            TYPE_BRANCH: begin
              if (hd.jump != hd.pred_jump) begin
                rollback    <= 1'b1;
                rollback_pc <= hd.jump ? hd.target : hd.pc + 32'd4;
              end
            end
            default: ;
          endcase
        end
        count <= count + CNT_W'(do_issue) - CNT_W'(do_retire);
      end
    end
  end

`ifdef ROB_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_retired <= '0;
      perf_flush   <= '0;
    end else if (rdy) begin
      if (do_retire) perf_retired <= perf_retired + 32'd1;
      if (rollback)  perf_flush   <= perf_flush + 32'd1;
    end
  end
`endif

  a_no_issue_when_full: assert property (@(posedge clk) disable iff (rst)
    (rdy && issue && !rollback) |-> !rob_full)
    else $warning("reorder_buffer: issue while full ignored");

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer between Decoder/execution units and the register file.
- Allocates one entry per issued instruction and captures results from the ALU and LSB broadcast buses.
- Retires the head entry in program order, driving the register file's commit port and the LSB's store-commit.
- Detects branch mispredictions at retirement and flushes the pipeline.

Parameters:
- ROB_SIZE, 16, number of entries; must equal 2**ROB_POS_W.
- ROB_POS_W, 4, entry index width; ROB id = {1'b1, pos}, 5 bits.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; when low all state holds
- rob_full  out  1  no free entry (count == ROB_SIZE), combinational
- rob_next_pos  out  4  tail index for the issuing instruction
- issue  in  1  allocate entry at tail
- issue_rd  in  5  destination register (0 = no register write)
- issue_type  in  2  0=reg-write, 1=store, 2=branch
- issue_pred_jump  in  1  predicted taken
- issue_pc  in  32  instruction pc
- issue_ready  in  1  result already known at issue (e.g. LUI)
- issue_val  in  32  result when issue_ready=1
- alu_valid, alu_pos, alu_val, alu_jump, alu_target  in  1/4/32/1/32  ALU writeback
- lsb_valid, lsb_pos, lsb_val  in  1/4/32  load writeback
- q1_pos, q2_pos  in  4  operand queries from Decoder
- q1_ready, q2_ready  out  1  entry value available, combinational
- q1_val, q2_val  out  32  entry value, combinational
- commit  out  1  register-file commit strobe (reg-write entries only)
- commit_rd  out  5  commit destination
- commit_val  out  32  commit value
- commit_pos  out  4  retiring entry index
- store_commit  out  1  LSB may perform head store
- rollback  out  1  flush pulse
- rollback_pc  out  32  corrected fetch pc

Behaviour:
- Reset: head=tail=count=0; all busy/ready bits cleared. Registered outputs commit, store_commit and rollback are 0. rollback_pc=0, commit_rd=0, commit_val=0.
- rdy=0: no state change; registered outputs hold their values.
- Issue: on issue & !rob_full, write the entry at tail (busy=1, ready=issue_ready).
  - tail wraps from ROB_SIZE-1 to 0.
  - Issue while full is a protocol violation; it is ignored and flagged by a simulation assertion.
- Writeback: alu_valid/lsb_valid set ready at the given pos and store val (plus jump and target for branches). Both buses may target different entries in the same cycle.
- Retire: evaluated each cycle on head (busy & ready); entries retire at most one per cycle, one cycle after writeback.
  - Reg-write: commit=1 with rd and val. When rd=0, commit stays 0 but the entry still retires.
  - Store: store_commit=1 for one cycle.
  - Branch: when jump != pred_jump, rollback=1 and rollback_pc = jump ? target : pc+4.
- Retiring entry: busy cleared, head advances with wrap.
- Simultaneous issue and retire: count unchanged. Full with retire in the same cycle: rob_full still reads 1 that cycle (no same-cycle reuse).
- Rollback cycle (rollback registered high): head=tail=count=0, all busy cleared, issue and writebacks that cycle ignored. rollback drops the next cycle.
- Queries: return ready/val for the entry.
  - Bypass from alu/lsb buses in the same cycle when pos matches.
  - Query of a non-busy entry returns ready=0.
- Strobes: commit, store_commit and rollback are single-cycle pulses.

Optional Feature:
- ROB_PERF_CNT_EN defined: adds outputs perf_retired[31:0] and perf_flush[31:0].
  - Reset to 0; increment on every retirement and every rollback respectively; wrap at 2^32.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- macros.v holds ROB_SIZE, ROB_POS_WID, ROB_ID_WID, REG_POS_WID, DATA_WID, and the issue_type encodings.
- No sub-module; pointer and count logic stays inline.

Test Plan:
- Reset, then issue rd=5 issue_ready=1 val=0x1234 → next cycle commit=1, commit_rd=5, commit_val=0x1234, commit_pos=0.
- Issue 16 entries without writeback → rob_full=1. A 17th issue is ignored; tail and count stay unchanged.
- Issue pos0, pos1; writeback pos1 then pos0 → commits pos0 then pos1 in order, one per cycle.
- Branch issued pred_jump=0 at pc=0x100; ALU returns jump=1, target=0x200 → rollback=1, rollback_pc=0x200; next cycle count=0 and rob_full=0.
- Query q1_pos=3 while alu_valid writes pos3 val=0xAB in the same cycle → q1_ready=1, q1_val=0xAB combinationally.
- Wrap: fill and drain across entry 15→0 twice with interleaved issue and retire → values retire in program order with no loss.
